// File: rtl/vrc_pkg.sv
// Shared constants, loader state type and CRC-8 step for the VRC configuration loader.
// The frame length follows the VRC_CFG_CRC_EN build option (CRC-8 trailer vs. single parity bit).
package vrc_pkg;

  localparam int         CFG_W         = 86;
  localparam logic [7:0] CRC_POLY      = 8'h07;
  localparam int         FRAME_LEN_CRC = CFG_W + 8;
  localparam int         FRAME_LEN_PAR = CFG_W + 1;

`ifdef VRC_CFG_CRC_EN
  localparam int FRAME_LEN = FRAME_LEN_CRC;
`else
  localparam int FRAME_LEN = FRAME_LEN_PAR;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } ld_state_e;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/vrc_cfg_check.sv
// Serial frame integrity accumulator: CRC-8 residual with VRC_CFG_CRC_EN, even parity otherwise.
// Every frame bit, check bits included, is fed in; match is valid once the whole frame is in.
module vrc_cfg_check
  import vrc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic en,
  input  logic bit_in,
  output logic match
);

`ifdef VRC_CFG_CRC_EN
  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = 8'h00;
    else if (en) crc_d = crc8_step(crc_q, bit_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 8'h00;
    else        crc_q <= crc_d;
  end

  // Shifting the received CRC through the same register leaves zero iff it matched.
  assign match = (crc_q == 8'h00);
`else
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (init)    par_d = 1'b0;
    else if (en) par_d = par_q ^ bit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign match = ~par_q;
`endif

endmodule

// File: rtl/vrc_cfg_loader.sv
// Serial genome loader: shifts a frame into a shadow, checks it, commits atomically to sel.
// Build option VRC_CFG_CRC_EN selects the CRC-8 frame format (parity frame when undefined).
//
// state    | meaning
// ST_IDLE  | waiting for cfg_start; sel holds last committed genome
// ST_LOAD  | accepting frame bits into shadow/checker
// ST_CHECK | one cycle: commit shadow on match, else flag cfg_err
module vrc_cfg_loader
  import vrc_pkg::*;
#(
  parameter logic [CFG_W-1:0] RESET_CFG = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] sel,
  output logic             sel_update,
  output logic             cfg_err,
  output logic             busy
);

  ld_state_e        state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] sel_q, sel_d;
  logic             sel_update_q, sel_update_d;
  logic             cfg_err_q, cfg_err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             chk_init, chk_en, chk_match;

  vrc_cfg_check u_check (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (chk_init),
    .en     (chk_en),
    .bit_in (cfg_bit),
    .match  (chk_match)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    sel_d        = sel_q;
    sel_update_d = 1'b0;
    cfg_err_d    = cfg_err_q;
    chk_init     = 1'b0;
    chk_en       = 1'b0;

    if (cfg_start) begin
      // Start wins over any bit or check result; outside IDLE it is an abort.
      state_d   = ST_LOAD;
      cnt_d     = '0;
      shadow_d  = '0;
      chk_init  = 1'b1;
      cfg_err_d = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_LOAD: begin
          cfg_err_d = 1'b0;
          if (cfg_valid) begin
            chk_en = 1'b1;
            cnt_d  = cnt_q + 7'd1;
            if (cnt_q < 7'(CFG_W))
              shadow_d = {shadow_q[CFG_W-2:0], cfg_bit};
            if (cnt_q == 7'(FRAME_LEN - 1))
              state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if (chk_match) begin
            sel_d        = shadow_q;
            sel_update_d = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      sel_q        <= RESET_CFG;
      sel_update_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      sel_update_q <= sel_update_d;
      cfg_err_q    <= cfg_err_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign busy       = busy_q;
  assign sel        = sel_q;
  assign sel_update = sel_update_q;
  assign cfg_err    = cfg_err_q;

endmodule
